// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Multi-cycle sequencer for the 8-bit accumulator ALU. Each instruction is
// fetched over a req/ack port and decoded into ALU control fields. It then
// steps through FETCH -> DECODE -> EXEC -> (MEM) -> WB. The block owns the
// program counter and the shift-carry flag. It issues single-cycle write
// strobes in WB.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a wait counter bounds every FETCH/MEM ack wait to TIMEOUT
//   cycles. On expiry the sequencer raises a sticky err and halts.
//   When undefined, waits are unbounded and err is tied low.
//
// Instruction word (9 bits):
//   instr[8] = type (0: R-type, 1: I-type)
//   R-type : rOp = instr[7:4], reg_idx = instr[3:0]
//   I-type : iOp = instr[7:5], imm     = instr[4:0]
//
// R-type opcode map:
//   0000 ADD   0001 SUB   0010 AND   0011 OR
//   0100 XOR   0101 RXOR  0110 SLR   0111 SRR
//   1000 LW    1001 SW    1010 EQ    1011 SLT
//   1100 LA    1101 SET   1110 BR    1111 J
//
// I-type opcode map:
//   000 ADDI  001 SUBI  010 SLL  011 SRL  100/101 other accumulator ops
//   110 NOP   111 HALT
//
// Ports:
//   clk, reset_n                clock, async active-low reset
//   start                       level start request (IDLE only)
//   imem_req/addr/ack/data      instruction fetch handshake
//   type_code, r_op, i_op, imm  decoded ALU controls
//   reg_idx                     register index
//   sc_in                       held shift-carry flag to the ALU
//   alu_sc_out, alu_branch,     ALU status and result
//   alu_rslt
//   acc_we, acc_sel_mem         accumulator write strobe and source select
//   reg_we                      register-file write strobe
//   dmem_req/we/ack             data memory handshake
//   pc, halted, err             status
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int PC_W    = 10,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [8:0]      imem_data,
    output logic            type_code,
    output logic [3:0]      r_op,
    output logic [2:0]      i_op,
    output logic [4:0]      imm,
    output logic [3:0]      reg_idx,
    output logic            sc_in,
    input  logic            alu_sc_out,
    input  logic            alu_branch,
    input  logic [7:0]      alu_rslt,
    output logic            acc_we,
    output logic            acc_sel_mem,
    output logic            reg_we,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLR = 4'b0110;
    localparam logic [3:0] OP_SRR = 4'b0111;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_SET = 4'b1101;
    localparam logic [3:0] OP_BR  = 4'b1110;
    localparam logic [3:0] OP_J   = 4'b1111;

    logic [2:0]      state;
    logic [8:0]      instr;
    logic            type_q;
    logic [3:0]      r_op_q;
    logic [2:0]      i_op_q;
    logic [4:0]      imm_q;
    logic [3:0]      reg_idx_q;
    logic            sc;
    logic            branch_q;
    logic            sc_out_q;
    logic [PC_W-1:0] pc_q;
    logic            timed_out;

    logic is_lw, is_sw, is_set, is_br, is_j, is_halt, wr_acc, upd_sc;

    // Instruction classification from the registered decode fields. These
    // fields are stable from EXEC through WB, so the strobes derived from
    // them are glitch-free in WB.
    always_comb begin
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_set  = 1'b0;
        is_br   = 1'b0;
        is_j    = 1'b0;
        is_halt = 1'b0;
        wr_acc  = 1'b0;
        upd_sc  = 1'b0;
        if (type_q) begin
            is_halt = (i_op_q == 3'b111);
            wr_acc  = (i_op_q <= 3'b101);
            upd_sc  = (i_op_q <= 3'b011);
        end else begin
            is_lw  = (r_op_q == OP_LW);
            is_sw  = (r_op_q == OP_SW);
            is_set = (r_op_q == OP_SET);
            is_br  = (r_op_q == OP_BR);
            is_j   = (r_op_q == OP_J);
            wr_acc = !(is_sw || is_set || is_br || is_j);
            upd_sc = (r_op_q == OP_ADD) || (r_op_q == OP_SUB) ||
                     (r_op_q == OP_SLR) || (r_op_q == OP_SRR);
        end
    end

    // Main sequencer. The ALU operands stay fixed from DECODE onwards, so
    // alu_rslt still holds the jump or branch target when WB loads the PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            instr     <= '0;
            type_q    <= 1'b0;
            r_op_q    <= '0;
            i_op_q    <= '0;
            imm_q     <= '0;
            reg_idx_q <= '0;
            sc        <= 1'b0;
            branch_q  <= 1'b0;
            sc_out_q  <= 1'b0;
            pc_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_data;
                        state <= ST_DECODE;
                    end else if (timed_out) begin
                        state <= ST_HALT;
                    end
                end
                ST_DECODE: begin
                    type_q    <= instr[8];
                    r_op_q    <= instr[7:4];
                    reg_idx_q <= instr[3:0];
                    i_op_q    <= instr[7:5];
                    imm_q     <= instr[4:0];
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    branch_q <= alu_branch;
                    sc_out_q <= alu_sc_out;
                    if (is_halt)              state <= ST_HALT;
                    else if (is_lw || is_sw)  state <= ST_MEM;
                    else                      state <= ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ack)       state <= ST_WB;
                    else if (timed_out) state <= ST_HALT;
                end
                ST_WB: begin
                    if (upd_sc) sc <= sc_out_q;
                    if (is_j || (is_br && branch_q)) pc_q <= PC_W'(alu_rslt);
                    else                             pc_q <= pc_q + 1'b1;
                    state <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;

    assign waiting   = ((state == ST_FETCH) && !imem_ack) ||
                       ((state == ST_MEM)   && !dmem_ack);
    assign timed_out = waiting && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Wait counter runs only while an ack is outstanding. Any non-waiting
    // cycle clears it, which covers both ack arrival and state entry.
    // err is sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (waiting) wait_cnt <= wait_cnt + 1'b1;
            else         wait_cnt <= '0;
            if (timed_out) err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT;
    assign timed_out      = 1'b0;
    assign err            = 1'b0;
`endif

    // Requests are decoded straight from state, so an async reset drops
    // them immediately.
    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = pc_q;
    assign dmem_req    = (state == ST_MEM);
    assign dmem_we     = (state == ST_MEM) && is_sw;
    assign acc_we      = (state == ST_WB) && wr_acc;
    assign acc_sel_mem = (state == ST_WB) && is_lw;
    assign reg_we      = (state == ST_WB) && is_set;
    assign halted      = (state == ST_HALT);
    assign pc          = pc_q;
    assign sc_in       = sc;
    assign type_code   = type_q;
    assign r_op        = r_op_q;
    assign i_op        = i_op_q;
    assign imm         = imm_q;
    assign reg_idx     = reg_idx_q;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle sequencer that drives the 8-bit accumulator ALU.
- Fetches 9-bit instructions through a req/ack instruction port and decodes them into ALU controls (typeCode, rOp, iOp, imm, register index).
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, owns the PC and the shift-carry flag, and issues accumulator, register-file, data-memory and PC-load strobes.
- Sits between the instruction memory, register file, ALU and data memory in the processor top level.

Parameters:
PC_W, 10, program counter width in bits
TIMEOUT, 15, max cycles waiting for a memory ack (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  level; leaves IDLE when high
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  instruction valid this cycle
imem_data  in  9  instruction word
type_code  out  1  to ALU typeCode
r_op  out  4  to ALU rOp
i_op  out  3  to ALU iOp
imm  out  5  to ALU imm
reg_idx  out  4  register-file index for opReg / SET destination
sc_in  out  1  to ALU scIn (held carry flag)
alu_sc_out  in  1  from ALU scOut
alu_branch  in  1  from ALU branch
alu_rslt  in  8  from ALU rslt (branch target / mem address)
acc_we  out  1  accumulator write strobe
acc_sel_mem  out  1  1: accumulator takes dmem_rdata, 0: ALU result
reg_we  out  1  register-file write strobe (SET)
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load, valid with dmem_req
dmem_ack  in  1  data access complete
pc  out  PC_W  current program counter
halted  out  1  high in HALT
err  out  1  timeout error (MEM_TIMEOUT_EN only, else tied 0)

Behaviour:
- Encoding: instr[8]=type.
  - R-type: rOp=instr[7:4], reg_idx=instr[3:0].
  - I-type: iOp=instr[7:5], imm=instr[4:0].
  - iOp 111 = HALT; iOp 110 = NOP.
- Reset: state=IDLE, pc=0, sc=0, instr register=0. All strobes, req, halted and err = 0.
- IDLE: when start=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc held stable until imem_ack.
  - On ack, latch imem_data and go to DECODE. Zero-wait ack gives a 1-cycle FETCH.
- DECODE: 1 cycle. Decoded fields are registered and held constant through WB.
- EXEC: 1 cycle. ALU settles; alu_branch and alu_sc_out are sampled at the end of the cycle.
  - LW (1000) and SW (1001) go to MEM.
  - HALT goes to HALT.
  - Everything else goes to WB.
- MEM:
  - dmem_req=1, dmem_we=1 for SW and 0 for LW, held until dmem_ack, then go to WB.
  - Address/data come from the datapath (alu_rslt, acc); the controller only sequences.
- WB: exactly one cycle; every strobe below is a single-cycle pulse.
  - acc_we=1 for R ADD, SUB, AND, OR, XOR, RXOR, SLR, SRR, EQ, SLT, LA, for all I-type 000–101, and for LW (LW also sets acc_sel_mem=1).
  - reg_we=1 for SET.
  - SW, BR, J and NOP: no write strobe.
  - sc updated from alu_sc_out for ADD, SUB, SLR, SRR, ADDI, SUBI, SLL, SRL; otherwise held.
  - PC:
    - pc <= alu_rslt[PC_W-1:0] (zero-extended) for J, or for BR with the sampled branch=1.
    - Otherwise pc <= pc+1, wrapping from 2^PC_W-1 to 0.
  - Next state: FETCH.
- Per-instruction cycles: 4 plus ack waits; 5 plus waits for LW/SW.
- HALT: halted=1. Stays until reset; start is ignored.
- Reset asserted mid-instruction aborts immediately to the reset values. Any pending req drops asynchronously.
- An ack arriving when no req is asserted is ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter runs while FETCH or MEM waits for its ack.
  - If TIMEOUT cycles elapse without ack: drop req, set err=1 (sticky), enter HALT with halted=1.
  - The counter clears on ack and on entry to each state.
- Undefined: no counter; waits are unbounded; err tied 0.

Test Plan:
- Reset, start=1, zero-wait imem with ADDI imm=5 at pc0 → imem_req rises cycle 1; acc_we pulses once in WB (4th active cycle); pc becomes 1.
- LW at pc0, dmem_ack delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0; acc_we=1 with acc_sel_mem=1 for one cycle; pc=1.
- BR with alu_branch=1, alu_rslt=0x20, then BR with alu_branch=0 → pc=0x20, then pc=0x21.
- ADD with alu_sc_out=1, then AND with alu_sc_out=0 → sc_in=1 after ADD and still 1 after AND.
- pc=2^PC_W-1 executing NOP → pc wraps to 0; no write strobes.
- HALT instruction → halted=1, imem_req stays 0 for 20 cycles. With MEM_TIMEOUT_EN, withholding imem_ack for 15 cycles → err=1, halted=1, imem_req=0.
